// File: rtl/lcd_sched_pkg.sv
// Shared definitions for the LCD update scheduler: sequencer states, HD44780
// command bytes, sequence lengths and byte-selection helpers.
package lcd_sched_pkg;

  typedef enum logic [2:0] {
    WAIT_RDY,
    INIT,
    PICK,
    SEND,
    WAIT_DONE,
    GAP,
    IDLE
  } sched_state_t;

  localparam logic [7:0] FUNC_SET   = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] ENTRY      = 8'h06;
  localparam logic [7:0] LINE1_ADDR = 8'h80;
  localparam logic [7:0] LINE2_ADDR = 8'hC0;

  localparam int unsigned LINE_CHARS = 16;
  localparam int unsigned INIT_LEN   = 4;

  // Byte index of the final byte in each kind of sequence. A line service is
  // the address command at index 0 followed by characters at 1..LINE_CHARS.
  localparam logic [4:0] INIT_LAST = 5'(INIT_LEN - 1);
  localparam logic [4:0] LINE_LAST = 5'(LINE_CHARS);

  function automatic logic [7:0] init_cmd(input logic [4:0] idx);
    logic [7:0] cmd;
    case (idx)
      5'd0:    cmd = FUNC_SET;
      5'd1:    cmd = DISP_ON;
      5'd2:    cmd = CLEAR;
      default: cmd = ENTRY;
    endcase
    return cmd;
  endfunction

  // Character idx (0 = leftmost) of a 16-char line packed MSB-first.
  function automatic logic [7:0] line_char(input logic [127:0] text,
                                           input logic [4:0]   idx);
    logic [127:0] shifted;
    shifted = text << {idx, 3'b000};
    return shifted[127:120];
  endfunction

endpackage

// File: rtl/lcd_line_arbiter.sv
// Round-robin arbiter between the two line requesters.
//   clk, iRST_N    : clock, asynchronous active-low reset
//   req1, req2     : content-changed pulses for line 1 / line 2
//   set_all        : mark both lines pending (end of panel init)
//   grant_en       : accept the current grant (scheduler in PICK)
//   grant_valid    : at least one line pending
//   grant_line2    : 0 = line 1 granted, 1 = line 2 granted
//   pend_any       : registered OR of the pending flags
//   pend_any_nxt   : value pend_any takes after the next edge
module lcd_line_arbiter
  import lcd_sched_pkg::*;
(
  input  logic clk,
  input  logic iRST_N,
  input  logic req1,
  input  logic req2,
  input  logic set_all,
  input  logic grant_en,
  output logic grant_valid,
  output logic grant_line2,
  output logic pend_any,
  output logic pend_any_nxt
);

  logic pend1, pend2, last2;
  logic pend1_nxt, pend2_nxt;
  logic take1, take2;

  always_comb begin
    grant_valid = pend1 | pend2;
    // With both pending, serve the line not served last.
    grant_line2 = pend2 & (~pend1 | ~last2);
    take1       = grant_en & grant_valid & ~grant_line2;
    take2       = grant_en & grant_valid &  grant_line2;
    // A request coinciding with its own grant keeps the flag set so the
    // line is written again with the newer content.
    pend1_nxt   = set_all | req1 | (pend1 & ~take1);
    pend2_nxt   = set_all | req2 | (pend2 & ~take2);
    pend_any    = pend1 | pend2;
    pend_any_nxt = pend1_nxt | pend2_nxt;
  end

  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      pend1 <= 1'b0;
      pend2 <= 1'b0;
      last2 <= 1'b1;
    end else begin
      pend1 <= pend1_nxt;
      pend2 <= pend2_nxt;
      if (take1)
        last2 <= 1'b0;
      else if (take2)
        last2 <= 1'b1;
    end
  end

endmodule

// File: rtl/lcd_update_scheduler.sv
// Sequencing controller for a 16x2 character LCD. Initialises the panel once,
// then rewrites line 1 or line 2 whenever that line is flagged as changed.
//   DLY_CYCLES : gap counter terminal value (gap = DLY_CYCLES+1 cycles)
//   clk, iRST_N: clock, asynchronous active-low reset
//   iReady     : panel warm-up complete (only looked at before init)
//   iLine1/2   : line text, char 0 in [127:120]
//   iReq1/2    : single-cycle "line content changed" pulses
//   oLCD_DATA, oLCD_RS, oLCD_Start / iLCD_Done : byte controller handshake
//   oBusy      : sequence in progress or a line pending
module lcd_update_scheduler
  import lcd_sched_pkg::*;
#(
  parameter logic [17:0] DLY_CYCLES = 18'h3FFFE
) (
  input  logic         clk,
  input  logic         iRST_N,
  input  logic         iReady,
  input  logic [127:0] iLine1,
  input  logic [127:0] iLine2,
  input  logic         iReq1,
  input  logic         iReq2,
  output logic [7:0]   oLCD_DATA,
  output logic         oLCD_RS,
  output logic         oLCD_Start,
  input  logic         iLCD_Done,
  output logic         oBusy
);

  sched_state_t state, state_n;
  logic [4:0]   byte_idx, idx_n, nxt_idx;
  logic [17:0]  gap_cnt, gap_n;
  logic         in_init, init_n;
  logic [127:0] shadow, shadow_n;
  logic [7:0]   data_n;
  logic         rs_n, start_n, busy_n;

  logic grant_en, set_all;
  logic grant_valid, grant_line2, pend_any, pend_any_nxt;

  lcd_line_arbiter u_arb (
    .clk          (clk),
    .iRST_N       (iRST_N),
    .req1         (iReq1),
    .req2         (iReq2),
    .set_all      (set_all),
    .grant_en     (grant_en),
    .grant_valid  (grant_valid),
    .grant_line2  (grant_line2),
    .pend_any     (pend_any),
    .pend_any_nxt (pend_any_nxt)
  );

  // Output registers are loaded on the transition into SEND, so the byte and
  // start strobe are visible for the whole SEND cycle and held until done.
  always_comb begin
    state_n  = state;
    idx_n    = byte_idx;
    gap_n    = gap_cnt;
    init_n   = in_init;
    shadow_n = shadow;
    data_n   = oLCD_DATA;
    rs_n     = oLCD_RS;
    start_n  = oLCD_Start;
    grant_en = 1'b0;
    set_all  = 1'b0;
    nxt_idx  = byte_idx + 5'd1;

    unique case (state)
      WAIT_RDY: begin
        if (iReady)
          state_n = INIT;
      end
      INIT: begin
        init_n  = 1'b1;
        idx_n   = '0;
        data_n  = init_cmd(5'd0);
        rs_n    = 1'b0;
        start_n = 1'b1;
        state_n = SEND;
      end
      PICK: begin
        if (grant_valid) begin
          grant_en = 1'b1;
          shadow_n = grant_line2 ? iLine2 : iLine1;
          init_n   = 1'b0;
          idx_n    = '0;
          data_n   = grant_line2 ? LINE2_ADDR : LINE1_ADDR;
          rs_n     = 1'b0;
          start_n  = 1'b1;
          state_n  = SEND;
        end else begin
          state_n = IDLE;
        end
      end
      SEND: begin
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (iLCD_Done) begin
          start_n = 1'b0;
          gap_n   = '0;
          state_n = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == DLY_CYCLES) begin
          if (in_init && byte_idx == INIT_LAST) begin
            set_all = 1'b1;
            state_n = PICK;
          end else if (!in_init && byte_idx == LINE_LAST) begin
            state_n = PICK;
          end else begin
            idx_n   = nxt_idx;
            start_n = 1'b1;
            state_n = SEND;
            if (in_init) begin
              data_n = init_cmd(nxt_idx);
              rs_n   = 1'b0;
            end else begin
              data_n = line_char(shadow, nxt_idx - 5'd1);
              rs_n   = 1'b1;
            end
          end
        end else begin
          gap_n = gap_cnt + 18'd1;
        end
      end
      IDLE: begin
        if (pend_any)
          state_n = PICK;
      end
      default: state_n = WAIT_RDY;
    endcase

    busy_n = !((state_n == WAIT_RDY) || (state_n == IDLE && !pend_any_nxt));
  end

  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= WAIT_RDY;
      byte_idx   <= '0;
      gap_cnt    <= '0;
      in_init    <= 1'b0;
      shadow     <= '0;
      oLCD_DATA  <= '0;
      oLCD_RS    <= 1'b0;
      oLCD_Start <= 1'b0;
      oBusy      <= 1'b0;
    end else begin
      state      <= state_n;
      byte_idx   <= idx_n;
      gap_cnt    <= gap_n;
      in_init    <= init_n;
      shadow     <= shadow_n;
      oLCD_DATA  <= data_n;
      oLCD_RS    <= rs_n;
      oLCD_Start <= start_n;
      oBusy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_lcd_update_scheduler.sv
// Scoreboard bench for lcd_update_scheduler with a byte-controller model.
module tb_lcd_update_scheduler;

  localparam logic [17:0] DLY = 18'd3;

  logic         clk = 1'b0;
  logic         iRST_N = 1'b0;
  logic         iReady = 1'b0;
  logic [127:0] iLine1;
  logic [127:0] iLine2;
  logic         iReq1 = 1'b0;
  logic         iReq2 = 1'b0;
  logic [7:0]   oLCD_DATA;
  logic         oLCD_RS;
  logic         oLCD_Start;
  logic         iLCD_Done = 1'b0;
  logic         oBusy;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;   // expected cycles from done pulse to next start; 0 = unchecked
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   lat = 2;
  int   last_done = -100;
  logic prev_start = 1'b0;

  lcd_update_scheduler #(.DLY_CYCLES(DLY)) dut (
    .clk        (clk),
    .iRST_N     (iRST_N),
    .iReady     (iReady),
    .iLine1     (iLine1),
    .iLine2     (iLine2),
    .iReq1      (iReq1),
    .iReq2      (iReq2),
    .oLCD_DATA  (oLCD_DATA),
    .oLCD_RS    (oLCD_RS),
    .oLCD_Start (oLCD_Start),
    .iLCD_Done  (iLCD_Done),
    .oBusy      (oBusy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic rs, input logic [7:0] d, input int gap);
    exp_t e;
    e.rs = rs; e.data = d; e.gap = gap;
    q.push_back(e);
  endtask

  // Within a sequence the gap is SEND->... done -> 4 GAP cycles -> SEND: 5.
  // A line address following a finished sequence passes through PICK: 6.
  task automatic push_line(input logic [7:0] addr, input logic [127:0] txt, input int gap0);
    push(1'b0, addr, gap0);
    for (int i = 0; i < 16; i++) push(1'b1, txt[127-8*i -: 8], 5);
  endtask

  task automatic push_init();
    push(1'b0, 8'h38, 0);
    push(1'b0, 8'h0C, 5);
    push(1'b0, 8'h01, 5);
    push(1'b0, 8'h06, 5);
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!(q.size() == 0 && !oBusy) && k < max_cyc);
    n_checks++;
    if (!(q.size() == 0 && !oBusy)) begin
      n_errors++;
      $display("FAIL %s: timeout, %0d bytes outstanding, busy=%0d", name, q.size(), oBusy);
    end
  endtask

  task automatic pulse(input logic r1, input logic r2);
    iReq1 = r1; iReq2 = r2;
    @(posedge clk); #1;
    iReq1 = 1'b0; iReq2 = 1'b0;
  endtask

  // Monitor: each rising oLCD_Start is one byte offered to the controller.
  always @(negedge clk) begin
    if (iLCD_Done) last_done = cyc;
    if (oLCD_Start && !prev_start) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_byte: got rs=%0d data=0x%02h, nothing expected", oLCD_RS, oLCD_DATA);
      end else begin
        mon_e = q.pop_front();
        check("byte_data", {24'd0, oLCD_DATA}, {24'd0, mon_e.data});
        check("byte_rs", {31'd0, oLCD_RS}, {31'd0, mon_e.rs});
        if (mon_e.gap != 0) check("byte_gap", cyc - last_done, mon_e.gap);
      end
    end
    prev_start = oLCD_Start;
  end

  // Byte controller model: done pulse `lat` cycles after start rises, while
  // confirming the byte and strobe stay stable during the wait.
  initial begin
    logic [7:0] cap_d;
    logic       cap_rs;
    logic       ok;
    logic       aborted;
    forever begin
      @(posedge clk); #1;
      if (oLCD_Start && iRST_N) begin
        cap_d = oLCD_DATA; cap_rs = oLCD_RS; ok = 1'b1; aborted = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(posedge clk); #1;
          if (!iRST_N) aborted = 1'b1;
          else if (!(oLCD_Start && oLCD_DATA == cap_d && oLCD_RS == cap_rs)) ok = 1'b0;
        end
        if (!aborted) begin
          check("start_data_stable", {31'd0, ok}, 32'd1);
          iLCD_Done = 1'b1;
          @(posedge clk); #1;
          iLCD_Done = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d bytes outstanding", q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] old_txt;
    int k;
    iLine1 = "Curr Card:  K   ";
    iLine2 = " P: 00  D: 00   ";

    // Reset values
    repeat (3) @(posedge clk); #1;
    check("rst_data",  {24'd0, oLCD_DATA}, 32'h00);
    check("rst_rs",    {31'd0, oLCD_RS}, 32'd0);
    check("rst_start", {31'd0, oLCD_Start}, 32'd0);
    check("rst_busy",  {31'd0, oBusy}, 32'd0);

    // Held in WAIT_RDY while iReady is low
    iRST_N = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("wait_rdy_start", {31'd0, oLCD_Start}, 32'd0);
    check("wait_rdy_busy",  {31'd0, oBusy}, 32'd0);

    // Power-up: init commands, then line 1 and line 2
    push_init();
    push_line(8'h80, iLine1, 6);
    push_line(8'hC0, iLine2, 6);
    iReady = 1'b1;
    @(posedge clk); #1;
    iReady = 1'b0;   // falling iReady after WAIT_RDY must not matter
    wait_idle("init_sequence", 3000);

    // Line 2 alone
    iLine2 = " P: 21  D: 17   ";
    push_line(8'hC0, iLine2, 0);
    pulse(1'b0, 1'b1);
    wait_idle("line2_update", 2000);

    // Line 1 alone with request-to-start latency
    push_line(8'h80, iLine1, 0);
    iReq1 = 1'b1;
    @(posedge clk); #1;           // edge N
    iReq1 = 1'b0;
    check("req_busy",     {31'd0, oBusy}, 32'd1);
    check("req_n_start",  {31'd0, oLCD_Start}, 32'd0);
    @(posedge clk); #1;           // N+1: PICK
    check("req_n1_start", {31'd0, oLCD_Start}, 32'd0);
    @(posedge clk); #1;           // N+2: SEND
    check("req_n2_start", {31'd0, oLCD_Start}, 32'd1);
    check("req_n2_data",  {24'd0, oLCD_DATA}, 32'h80);
    wait_idle("line1_update", 2000);

    // Simultaneous requests, last grant line 1: line 2 first
    push_line(8'hC0, iLine2, 0);
    push_line(8'h80, iLine1, 6);
    pulse(1'b1, 1'b1);
    wait_idle("both_requests", 3000);

    // Text change mid-line: old text completes, then a second pass
    old_txt = iLine1;
    push_line(8'h80, old_txt, 0);
    push_line(8'h80, "You Won!        ", 6);
    pulse(1'b1, 1'b0);
    k = 0;
    while (q.size() > 28 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    check("tear_reached_byte5", {31'd0, (q.size() <= 28)}, 32'd1);
    iLine1 = "You Won!        ";
    pulse(1'b1, 1'b0);
    wait_idle("no_tear", 3000);

    // Slow controller: strobe and byte held for the whole wait
    lat = 50;
    push_line(8'h80, iLine1, 0);
    pulse(1'b1, 1'b0);
    wait_idle("slow_controller", 5000);
    lat = 2;

    // Reset during WAIT_DONE
    push(1'b0, 8'hC0, 0);
    pulse(1'b0, 1'b1);
    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("abort_byte_seen", q.size(), 32'd0);
    #2;
    iRST_N = 1'b0;
    #1;
    check("abort_data",  {24'd0, oLCD_DATA}, 32'h00);
    check("abort_rs",    {31'd0, oLCD_RS}, 32'd0);
    check("abort_start", {31'd0, oLCD_Start}, 32'd0);
    check("abort_busy",  {31'd0, oBusy}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    iRST_N = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("rewait_start", {31'd0, oLCD_Start}, 32'd0);
    check("rewait_busy",  {31'd0, oBusy}, 32'd0);
    push_init();
    push_line(8'h80, iLine1, 6);
    push_line(8'hC0, iLine2, 6);
    iReady = 1'b1;
    wait_idle("reinit_sequence", 3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
